// File: rtl/l1d_ctrl_pkg.sv
// Shared types for the L1 data cache controller: FSM states, the posted
// write buffer entry layout and the critical-beat-first wrap helper.
package l1d_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_FILL_REQ = 3'd2,
    ST_FILL_GET = 3'd3,
    ST_FILL_OUT = 3'd4,
    ST_IO_REQ   = 3'd5,
    ST_IO_WAIT  = 3'd6
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wbuf_entry_t;

  // Beat index of the step-th beat of a fill that starts at 'start'.
  // 'mask' is LINE_BEATS-1, so the index wraps inside the line.
  function automatic logic [3:0] wrap_beat(input logic [3:0] start,
                                           input logic [3:0] step,
                                           input logic [3:0] mask);
    return (start + step) & mask;
  endfunction

endpackage

// File: rtl/l1_data_write_buffer.sv
// Posted write buffer: small synchronous FIFO with a show-ahead head entry.
module l1_data_write_buffer
  import l1d_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        push_i,
  input  wbuf_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output wbuf_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  wbuf_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Entry storage; contents only matter once the count says they are valid.
  always_ff @(posedge iCLOCK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/l1_data_cache_ctrl_wb.sv
// L1 data cache controller with configurable line length, critical-beat-first
// fill with early restart, and a posted write-through write buffer.
module l1_data_cache_ctrl_wb
  import l1d_ctrl_pkg::*;
#(
  parameter int unsigned LINE_BEATS    = 8,
  parameter int unsigned WBUF_DEPTH    = 4,
  parameter int unsigned IO_FIXED      = 0,
  parameter logic [31:0] IO_FIXED_ADDR = 32'hFFFF_0000
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iREMOVE,
  input  logic                    iIOSR_VALID,
  input  logic [31:0]             iIOSR,
  input  logic                    iLDST_REQ,
  output logic                    oLDST_BUSY,
  input  logic                    iLDST_RW,
  input  logic [3:0]              iLDST_MASK,
  input  logic [31:0]             iLDST_ADDR,
  input  logic [31:0]             iLDST_DATA,
  output logic                    oLDST_VALID,
  output logic [31:0]             oLDST_DATA,
  output logic                    oCACHE_RD_REQ,
  output logic [31:0]             oCACHE_RD_ADDR,
  input  logic                    iCACHE_RD_VALID,
  input  logic                    iCACHE_RD_HIT,
  input  logic [31:0]             iCACHE_RD_DATA,
  output logic                    oCACHE_UP_REQ,
  output logic [3:0]              oCACHE_UP_MASK,
  output logic [31:0]             oCACHE_UP_ADDR,
  output logic [31:0]             oCACHE_UP_DATA,
  output logic                    oCACHE_WR_REQ,
  output logic [31:0]             oCACHE_WR_ADDR,
  output logic [64*LINE_BEATS-1:0] oCACHE_WR_DATA,
  output logic                    oCACHE_FLUSH,
  output logic                    oDATA_REQ,
  input  logic                    iDATA_LOCK,
  output logic                    oDATA_RW,
  output logic [3:0]              oDATA_MASK,
  output logic [31:0]             oDATA_ADDR,
  output logic [31:0]             oDATA_DATA,
  input  logic                    iDATA_VALID,
  input  logic [63:0]             iDATA_DATA,
  output logic                    oIO_REQ,
  input  logic                    iIO_BUSY,
  output logic                    oIO_RW,
  output logic [31:0]             oIO_ADDR,
  output logic [31:0]             oIO_DATA,
  input  logic                    iIO_VALID,
  input  logic [31:0]             iIO_DATA
);

  localparam int unsigned IDXW      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned CW        = $clog2(LINE_BEATS + 1);
  localparam int unsigned OCW       = $clog2(2 * WBUF_DEPTH + 1);
  localparam logic [OCW-1:0] OC_MAX = OCW'(2 * WBUF_DEPTH);
  localparam logic [3:0]  BEAT_MASK = 4'(LINE_BEATS - 1);
  localparam logic [31:0] LINE_MASK = 32'(LINE_BEATS * 8 - 1);
  localparam logic [CW-1:0] LAST    = CW'(LINE_BEATS - 1);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            rw_q, rw_d;
  logic [31:0]     iosr_q, iosr_d;
  logic            iosr_valid_q, iosr_valid_d;
  logic            flush_q, flush_d;
  logic            wr_ack_q, wr_ack_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   resp_q, resp_d;
  logic [OCW-1:0]  oc_q, oc_d;
  logic [63:0]     line_q [0:(1<<IDXW)-1];

  logic [31:0]     io_start;
  logic            io_ok;
  logic            req_is_io;
  logic            wbuf_push, wbuf_pop, wbuf_full, wbuf_empty;
  wbuf_entry_t     wbuf_head;
  logic            wbuf_quiet, in_fill, fill_rx, fill_issue, drain_issue;
  logic [3:0]      start_beat, issue_beat, resp_beat;
  logic [31:0]     line_base;

  assign io_start   = (IO_FIXED != 0) ? IO_FIXED_ADDR : iosr_q;
  assign io_ok      = (IO_FIXED != 0) || iosr_valid_q;
  assign req_is_io  = (iLDST_ADDR >= io_start);
  assign wbuf_quiet = wbuf_empty && (oc_q == '0);
  assign in_fill    = (state_q == ST_FILL_REQ) || (state_q == ST_FILL_GET);
  // A fill only starts with nothing outstanding and never bumps the count,
  // so with a zero count every response during a fill is a fill beat.
  assign fill_rx    = iDATA_VALID && in_fill && (oc_q == '0);
  assign fill_issue = (state_q == ST_FILL_REQ) && wbuf_quiet;
  // Fills and IO wait for an empty buffer, so draining never competes with them.
  assign drain_issue = !wbuf_empty && (oc_q != OC_MAX);
  assign wbuf_pop   = drain_issue && !iDATA_LOCK;
  assign start_beat = addr_q[6:3] & BEAT_MASK;
  assign issue_beat = wrap_beat(start_beat, 4'(issued_q), BEAT_MASK);
  assign resp_beat  = wrap_beat(start_beat, 4'(resp_q), BEAT_MASK);
  assign line_base  = addr_q & ~LINE_MASK;
  assign oCACHE_WR_ADDR = line_base;
  assign oCACHE_FLUSH   = iREMOVE;

  for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_line_out
    assign oCACHE_WR_DATA[gi*64 +: 64] = line_q[gi];
  end

  l1_data_write_buffer #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .iCLOCK       (iCLOCK),
    .inRESET      (inRESET),
    .push_i       (wbuf_push),
    .push_entry_i ('{addr: iLDST_ADDR, mask: iLDST_MASK, data: iLDST_DATA}),
    .pop_i        (wbuf_pop),
    .full_o       (wbuf_full),
    .empty_o      (wbuf_empty),
    .head_o       (wbuf_head)
  );

  // Next-state and output decode for the request FSM and the shared data bus.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rw_d         = rw_q;
    iosr_d       = iosr_q;
    iosr_valid_d = iosr_valid_q;
    flush_d      = flush_q;
    wr_ack_d     = 1'b0;
    issued_d     = issued_q;
    resp_d       = resp_q;
    oc_d         = oc_q;
    wbuf_push    = 1'b0;
    oLDST_BUSY   = 1'b1;
    oLDST_VALID  = wr_ack_q;
    oLDST_DATA   = '0;
    oCACHE_RD_REQ  = 1'b0;
    oCACHE_RD_ADDR = '0;
    oCACHE_UP_REQ  = 1'b0;
    oCACHE_UP_MASK = '0;
    oCACHE_UP_ADDR = '0;
    oCACHE_UP_DATA = '0;
    oCACHE_WR_REQ  = 1'b0;
    oDATA_REQ  = 1'b0;
    oDATA_RW   = 1'b0;
    oDATA_MASK = '0;
    oDATA_ADDR = '0;
    oDATA_DATA = '0;
    oIO_REQ    = 1'b0;
    oIO_RW     = rw_q;
    oIO_ADDR   = '0;
    oIO_DATA   = '0;

    if (iIOSR_VALID) begin
      iosr_d       = iIOSR;
      iosr_valid_d = 1'b1;
    end

    if (fill_issue) begin
      oDATA_REQ  = 1'b1;
      oDATA_RW   = 1'b1;
      oDATA_MASK = 4'hF;
      oDATA_ADDR = line_base | (32'(issue_beat) << 3);
    end else if (drain_issue) begin
      oDATA_REQ  = 1'b1;
      oDATA_MASK = wbuf_head.mask;
      oDATA_ADDR = wbuf_head.addr;
      oDATA_DATA = wbuf_head.data;
    end

    if (wbuf_pop && !(iDATA_VALID && !fill_rx))             oc_d = oc_q + OCW'(1);
    else if (!wbuf_pop && iDATA_VALID && !fill_rx && oc_q != '0) oc_d = oc_q - OCW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (io_ok) begin
          if (!iLDST_REQ) begin
            oLDST_BUSY = 1'b0;
          end else if (req_is_io) begin
            oLDST_BUSY = !wbuf_quiet;
            if (wbuf_quiet) begin
              addr_d  = iLDST_ADDR - io_start;
              data_d  = iLDST_DATA;
              rw_d    = iLDST_RW;
              state_d = ST_IO_REQ;
            end
          end else if (!iLDST_RW) begin
            oLDST_BUSY = wbuf_full;
            if (!wbuf_full) begin
              wbuf_push      = 1'b1;
              wr_ack_d       = 1'b1;
              oCACHE_UP_REQ  = 1'b1;
              oCACHE_UP_MASK = iLDST_MASK;
              oCACHE_UP_ADDR = iLDST_ADDR;
              oCACHE_UP_DATA = iLDST_DATA;
            end
          end else begin
            oLDST_BUSY     = 1'b0;
            oCACHE_RD_REQ  = 1'b1;
            oCACHE_RD_ADDR = {iLDST_ADDR[31:2], 2'b00};
            addr_d         = iLDST_ADDR;
            rw_d           = 1'b1;
            state_d        = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (iCACHE_RD_VALID && iCACHE_RD_HIT) begin
          oLDST_VALID = 1'b1;
          oLDST_DATA  = iCACHE_RD_DATA;
          state_d     = ST_IDLE;
        end else if (iCACHE_RD_VALID) begin
          issued_d = '0;
          resp_d   = '0;
          flush_d  = iREMOVE;
          state_d  = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        if (fill_issue && !iDATA_LOCK) begin
          issued_d = issued_q + CW'(1);
          if (issued_q == LAST) state_d = ST_FILL_GET;
        end
      end
      ST_FILL_GET: begin
        if (fill_rx && resp_q == LAST) state_d = ST_FILL_OUT;
      end
      ST_FILL_OUT: begin
        oCACHE_WR_REQ = (LINE_BEATS > 1) && !flush_q && !iREMOVE;
        state_d       = ST_IDLE;
      end
      ST_IO_REQ: begin
        oIO_REQ  = 1'b1;
        oIO_ADDR = addr_q;
        oIO_DATA = data_q;
        if (!iIO_BUSY) state_d = ST_IO_WAIT;
      end
      ST_IO_WAIT: begin
        if (iIO_VALID) begin
          oLDST_VALID = 1'b1;
          oLDST_DATA  = iIO_DATA;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_fill && iREMOVE) flush_d = 1'b1;

    // The first returning beat is the critical one: hand its word back early.
    if (fill_rx) begin
      resp_d = resp_q + CW'(1);
      if (resp_q == '0) begin
        oLDST_VALID = 1'b1;
        oLDST_DATA  = addr_q[2] ? iDATA_DATA[63:32] : iDATA_DATA[31:0];
      end
    end
  end

  // Control and request state registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      iosr_q       <= '0;
      iosr_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      wr_ack_q     <= 1'b0;
      issued_q     <= '0;
      resp_q       <= '0;
      oc_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
      iosr_q       <= iosr_d;
      iosr_valid_q <= iosr_valid_d;
      flush_q      <= flush_d;
      wr_ack_q     <= wr_ack_d;
      issued_q     <= issued_d;
      resp_q       <= resp_d;
      oc_q         <= oc_d;
    end
  end

  // Line assembly: each fill beat lands at its wrapped index.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < (1 << IDXW); i++) line_q[i] <= '0;
    end else if (fill_rx) begin
      line_q[resp_beat[IDXW-1:0]] <= iDATA_DATA;
    end
  end

endmodule

// File: tb/tb_l1_data_cache_ctrl_wb.sv
// Directed self-checking bench for l1_data_cache_ctrl_wb (LINE_BEATS=8, WBUF_DEPTH=4).
module tb_l1_data_cache_ctrl_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iREMOVE = 0, iIOSR_VALID = 0;
  logic [31:0]  iIOSR = '0;
  logic         iLDST_REQ = 0, iLDST_RW = 0;
  logic [3:0]   iLDST_MASK = '0;
  logic [31:0]  iLDST_ADDR = '0, iLDST_DATA = '0;
  logic         oLDST_BUSY, oLDST_VALID;
  logic [31:0]  oLDST_DATA;
  logic         oCACHE_RD_REQ;
  logic [31:0]  oCACHE_RD_ADDR;
  logic         iCACHE_RD_VALID = 0, iCACHE_RD_HIT = 0;
  logic [31:0]  iCACHE_RD_DATA = '0;
  logic         oCACHE_UP_REQ;
  logic [3:0]   oCACHE_UP_MASK;
  logic [31:0]  oCACHE_UP_ADDR, oCACHE_UP_DATA;
  logic         oCACHE_WR_REQ;
  logic [31:0]  oCACHE_WR_ADDR;
  logic [511:0] oCACHE_WR_DATA;
  logic         oCACHE_FLUSH;
  logic         oDATA_REQ, iDATA_LOCK = 0, oDATA_RW;
  logic [3:0]   oDATA_MASK;
  logic [31:0]  oDATA_ADDR, oDATA_DATA;
  logic         iDATA_VALID = 0;
  logic [63:0]  iDATA_DATA = '0;
  logic         oIO_REQ, iIO_BUSY = 0, oIO_RW;
  logic [31:0]  oIO_ADDR, oIO_DATA;
  logic         iIO_VALID = 0;
  logic [31:0]  iIO_DATA = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_data_cache_ctrl_wb #(
    .LINE_BEATS(8), .WBUF_DEPTH(4), .IO_FIXED(0), .IO_FIXED_ADDR(32'hFFFF_0000)
  ) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(iREMOVE),
    .iIOSR_VALID(iIOSR_VALID), .iIOSR(iIOSR),
    .iLDST_REQ(iLDST_REQ), .oLDST_BUSY(oLDST_BUSY), .iLDST_RW(iLDST_RW),
    .iLDST_MASK(iLDST_MASK), .iLDST_ADDR(iLDST_ADDR), .iLDST_DATA(iLDST_DATA),
    .oLDST_VALID(oLDST_VALID), .oLDST_DATA(oLDST_DATA),
    .oCACHE_RD_REQ(oCACHE_RD_REQ), .oCACHE_RD_ADDR(oCACHE_RD_ADDR),
    .iCACHE_RD_VALID(iCACHE_RD_VALID), .iCACHE_RD_HIT(iCACHE_RD_HIT),
    .iCACHE_RD_DATA(iCACHE_RD_DATA),
    .oCACHE_UP_REQ(oCACHE_UP_REQ), .oCACHE_UP_MASK(oCACHE_UP_MASK),
    .oCACHE_UP_ADDR(oCACHE_UP_ADDR), .oCACHE_UP_DATA(oCACHE_UP_DATA),
    .oCACHE_WR_REQ(oCACHE_WR_REQ), .oCACHE_WR_ADDR(oCACHE_WR_ADDR),
    .oCACHE_WR_DATA(oCACHE_WR_DATA), .oCACHE_FLUSH(oCACHE_FLUSH),
    .oDATA_REQ(oDATA_REQ), .iDATA_LOCK(iDATA_LOCK), .oDATA_RW(oDATA_RW),
    .oDATA_MASK(oDATA_MASK), .oDATA_ADDR(oDATA_ADDR), .oDATA_DATA(oDATA_DATA),
    .iDATA_VALID(iDATA_VALID), .iDATA_DATA(iDATA_DATA),
    .oIO_REQ(oIO_REQ), .iIO_BUSY(iIO_BUSY), .oIO_RW(oIO_RW),
    .oIO_ADDR(oIO_ADDR), .oIO_DATA(oIO_DATA),
    .iIO_VALID(iIO_VALID), .iIO_DATA(iIO_DATA)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Fill data pattern for beat index idx.
  function automatic logic [63:0] pat(input int idx);
    return {32'hA0A0_0000 + 32'(idx), 32'h5050_0000 + 32'(idx)};
  endfunction

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    iLDST_REQ = 1; iLDST_RW = 1; iLDST_ADDR = a;
    @(negedge clk);
    check("rd_accept", oLDST_BUSY, 0);
    check("rd_req", oCACHE_RD_REQ, 1);
    check("rd_addr", oCACHE_RD_ADDR, al);
    check("rd_not_io", oIO_REQ, 0);
    step_clk();
    iLDST_REQ = 0; iCACHE_RD_VALID = 1; iCACHE_RD_HIT = 1; iCACHE_RD_DATA = d;
    @(negedge clk);
    check("hit_valid", oLDST_VALID, 1);
    check("hit_data", oLDST_DATA, d);
    check("hit_no_mem", oDATA_REQ, 0);
    step_clk();
    iCACHE_RD_VALID = 0; iCACHE_RD_HIT = 0;
  endtask

  task automatic do_miss(input logic [31:0] a);
    iLDST_REQ = 1; iLDST_RW = 1; iLDST_ADDR = a;
    @(negedge clk);
    check("miss_accept", oLDST_BUSY, 0);
    step_clk();
    iLDST_REQ = 0; iCACHE_RD_VALID = 1; iCACHE_RD_HIT = 0;
    @(negedge clk);
    check("miss_no_valid", oLDST_VALID, 0);
    step_clk();
    iCACHE_RD_VALID = 0;
  endtask

  // Runs a whole fill from its first issue cycle; responses trail issues by 2 cycles.
  task automatic do_fill(input logic [31:0] base, input int start, input bit hi,
                         input int flush_k, input bit exp_wr);
    logic [63:0] p;
    for (int k = 0; k <= 11; k++) begin
      iDATA_VALID = (k >= 2 && k <= 9);
      iDATA_DATA  = iDATA_VALID ? pat((start + k - 2) % 8) : 64'h0;
      iREMOVE     = (k == flush_k);
      @(negedge clk);
      if (k < 8) begin
        check("fill_req", oDATA_REQ, 1);
        check("fill_rw", oDATA_RW, 1);
        check("fill_addr", oDATA_ADDR, base + 32'(((start + k) % 8) * 8));
      end else if (k < 10) begin
        check("fill_stop", oDATA_REQ, 0);
      end
      if (k == 2) begin
        p = pat(start);
        check("early_valid", oLDST_VALID, 1);
        check("early_data", oLDST_DATA, hi ? p[63:32] : p[31:0]);
      end
      if (k == 3) check("early_once", oLDST_VALID, 0);
      if (k == flush_k) check("flush_pulse", oCACHE_FLUSH, 1);
      if (k == flush_k + 1) check("flush_drop", oCACHE_FLUSH, 0);
      if (k == 10) begin
        check("install_req", oCACHE_WR_REQ, exp_wr);
        if (exp_wr) begin
          check("install_addr", oCACHE_WR_ADDR, base);
          for (int b = 0; b < 8; b++) check("install_beat", oCACHE_WR_DATA[b*64 +: 64], pat(b));
        end
      end
      if (k == 11) begin
        check("install_once", oCACHE_WR_REQ, 0);
        check("fill_idle", oLDST_BUSY, 0);
      end
      step_clk();
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", oLDST_BUSY, 1);
    check("rst_valid", oLDST_VALID, 0);
    check("rst_dreq", oDATA_REQ, 0);
    check("rst_wr", oCACHE_WR_REQ, 0);
    check("rst_io", oIO_REQ, 0);
    step_clk();
    rst_n = 1;
    step_clk();
    @(negedge clk);
    check("iosr_invalid_busy", oLDST_BUSY, 1);
    step_clk();
    iIOSR_VALID = 1; iIOSR = 32'h8000_0000;
    step_clk();
    iIOSR_VALID = 0;
    @(negedge clk);
    check("iosr_loaded_busy", oLDST_BUSY, 0);
    step_clk();

    // Hit path and memory-side classification boundary
    do_hit(32'h0000_0100, 32'hDEAD_BEEF);
    do_hit(32'h7FFF_FFFE, 32'h1234_5678);

    // Critical-beat-first miss at 0x1_0028
    do_miss(32'h0001_0028);
    do_fill(32'h0001_0000, 5, 1'b0, -1, 1'b1);

    // Four posted writes under lock, fifth blocked, then FIFO-order drain
    iLDST_MASK = 4'hF;
    for (int c = 0; c <= 10; c++) begin
      logic [31:0] a;
      a = (c < 4) ? 32'h300 + 32'(4 * c) : 32'h310;
      iLDST_REQ  = (c <= 6);
      iLDST_RW   = 0;
      iLDST_ADDR = a;
      iLDST_DATA = 32'h1111_0000 + ((a - 32'h300) >> 2);
      iDATA_LOCK = (c < 5);
      @(negedge clk);
      if (c <= 6) begin
        check("wr_busy", oLDST_BUSY, (c == 4 || c == 5));
        check("wr_update", oCACHE_UP_REQ, !(c == 4 || c == 5));
      end
      check("wr_ack", oLDST_VALID, ((c >= 1 && c <= 4) || c == 7));
      if (c >= 5 && c <= 9) begin
        check("drain_req", oDATA_REQ, 1);
        check("drain_rw", oDATA_RW, 0);
        check("drain_addr", oDATA_ADDR, 32'h300 + 32'(4 * (c - 5)));
        check("drain_data", oDATA_DATA, 32'h1111_0000 + 32'(c - 5));
      end
      if (c == 10) check("drain_done", oDATA_REQ, 0);
      step_clk();
    end
    iLDST_REQ = 0;
    iDATA_VALID = 1;
    repeat (5) step_clk();
    iDATA_VALID = 0;

    // Read-after-write ordering: fill waits for the write response
    iLDST_REQ = 1; iLDST_RW = 0; iLDST_ADDR = 32'h200; iLDST_DATA = 32'hCAFE_0001;
    @(negedge clk);
    check("raw_wr_accept", oLDST_BUSY, 0);
    step_clk();
    iLDST_RW = 1; iLDST_ADDR = 32'h240;
    @(negedge clk);
    check("raw_rd_accept", oLDST_BUSY, 0);
    check("raw_drain_addr", oDATA_ADDR, 32'h200);
    check("raw_drain_rw", oDATA_RW, 0);
    step_clk();
    iLDST_REQ = 0; iCACHE_RD_VALID = 1; iCACHE_RD_HIT = 0;
    step_clk();
    iCACHE_RD_VALID = 0;
    for (int c = 0; c < 4; c++) begin
      iDATA_VALID = (c == 3);
      @(negedge clk);
      check("raw_fill_held", oDATA_REQ, 0);
      step_clk();
    end
    iDATA_VALID = 0;
    do_fill(32'h240, 0, 1'b0, -1, 1'b1);

    // IO read with a busy target
    iLDST_REQ = 1; iLDST_RW = 1; iLDST_ADDR = 32'h8000_0010;
    @(negedge clk);
    check("io_accept", oLDST_BUSY, 0);
    check("io_no_lookup", oCACHE_RD_REQ, 0);
    step_clk();
    iLDST_REQ = 0;
    for (int c = 0; c < 4; c++) begin
      iIO_BUSY = (c < 3);
      @(negedge clk);
      check("io_req", oIO_REQ, 1);
      check("io_addr", oIO_ADDR, 32'h10);
      check("io_rw", oIO_RW, 1);
      step_clk();
    end
    iIO_BUSY = 0; iIO_VALID = 1; iIO_DATA = 32'h55;
    @(negedge clk);
    check("io_valid", oLDST_VALID, 1);
    check("io_data", oLDST_DATA, 32'h55);
    step_clk();
    iIO_VALID = 0;
    @(negedge clk);
    check("io_idle", oLDST_BUSY, 0);
    step_clk();

    // Flush in the middle of a fill: traffic completes, no install
    do_miss(32'h0000_0404);
    do_fill(32'h400, 0, 1'b1, 4, 1'b0);
    do_hit(32'h0000_0500, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
